// File: rtl/instr_mem_pkg.sv
// Shared types, defaults and the power-on image for the instruction memory.
// Used by both the ROM build and the INSTR_MEM_PROG_EN programmable build.
package instr_mem_pkg;

  localparam int unsigned DEPTH_DEFAULT = 256;
  localparam int unsigned WORD_BYTES    = 4;

  typedef logic [7:0]  instr_byte_t;
  typedef logic [31:0] instr_word_t;

  function automatic instr_byte_t default_byte(
    input int unsigned i
  );
    return i[7:0];
  endfunction

endpackage

// File: rtl/instr_mem_byte_array.sv
// Byte storage with async restore of the default image and one write port.
// Four combinational read ports feed the big-endian word assembly.
module instr_mem_byte_array
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  instr_byte_t             wdata_i,
  input  logic [3:0][AW-1:0]      raddr_i,
  output instr_byte_t [3:0]       rdata_o
);

  instr_byte_t mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= default_byte(i);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see mem_q directly, so a write shows up right after its edge.
  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign rdata_o[k] = mem_q[raddr_i[k]];
  end

endmodule

// File: rtl/instruction_mem.sv
// Byte-addressed instruction memory, big-endian combinational word fetch.
// Define INSTR_MEM_PROG_EN for the byte write port; otherwise a fixed ROM.
module instruction_mem
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              addr,
`ifdef INSTR_MEM_PROG_EN
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [7:0]               prog_data,
`endif
  output logic [31:0]              out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [3:0][32:0]   baddr;
  logic [3:0]         in_rng;
  logic [3:0][AW-1:0] ridx;
  instr_byte_t [3:0]  rbyte;
  instr_byte_t [3:0]  obyte;

  // 33-bit sums so addr near 2^32 never wraps back into the array.
  always_comb begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      baddr[k]  = {1'b0, addr} + 33'(k);
      in_rng[k] = baddr[k] < 33'(DEPTH);
      ridx[k]   = baddr[k][AW-1:0];
      obyte[k]  = in_rng[k] ? rbyte[k] : 8'h00;
    end
  end

  assign out = {obyte[0], obyte[1], obyte[2], obyte[3]};

`ifdef INSTR_MEM_PROG_EN
  instr_mem_byte_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (prog_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (ridx),
    .rdata_o (rbyte)
  );
`else
  always_comb begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      rbyte[k] = default_byte(32'(ridx[k]));
    end
  end

  // Clock and reset are kept on the port list but have no role in a ROM.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_instruction_mem.sv
// Directed bench for instruction_mem, default DEPTH=256.
// Covers ROM build and, with INSTR_MEM_PROG_EN, the write/reset paths.
module tb_instruction_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] out;
`ifdef INSTR_MEM_PROG_EN
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = 8'h00;
  logic [7:0]  prog_data = 8'h00;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  instruction_mem #(.DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
`ifdef INSTR_MEM_PROG_EN
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
`endif
    .out       (out)
  );

  task automatic check(input string tag, input logic [31:0] exp);
    compared++;
    assert (out === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, out, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input string tag,
                    input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    #11;
    rd(32'h0, "reset_addr0", 32'h00010203);
    rst = 1'b0;
    #2;

    rd(32'h00000000, "addr_00", 32'h00010203);
    rd(32'h00000005, "addr_05", 32'h05060708);
    rd(32'h00000009, "addr_09", 32'h090A0B0C);
    rd(32'h0000000D, "addr_0D", 32'h0D0E0F10);
    rd(32'h000000FD, "addr_FD", 32'hFDFEFF00);
    rd(32'h000000FE, "addr_FE", 32'hFEFF0000);
    rd(32'h000000FF, "addr_FF", 32'hFF000000);
    rd(32'h00000100, "addr_100", 32'h00000000);
    rd(32'hFFFFFFFF, "addr_max", 32'h00000000);
    rd(32'hFFFFFFFD, "addr_wrap", 32'h00000000);

`ifdef INSTR_MEM_PROG_EN
    // write 0xAA at byte 4, addr held
    @(negedge clk);
    addr = 32'h4;
    prog_we = 1'b1;
    prog_addr = 8'h04;
    prog_data = 8'hAA;
    #1 check("wr4_before", 32'h04050607);
    @(posedge clk);
    #1 check("wr4_after", 32'hAA050607);
    prog_we = 1'b0;
    rd(32'h00000002, "wr4_addr2", 32'h0203AA05);

    // write 0x55 at byte 0, then reset between edges
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 8'h00;
    prog_data = 8'h55;
    @(posedge clk);
    #1 prog_we = 1'b0;
    rd(32'h0, "wr0_after", 32'h55010203);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async_addr0", 32'h00010203);
    rd(32'h4, "rst_discard4", 32'h04050607);

    // writes ignored while reset held
    addr = 32'h0;
    prog_we = 1'b1;
    prog_addr = 8'h00;
    prog_data = 8'h77;
    @(posedge clk);
    #1 check("we_in_rst", 32'h00010203);
    @(negedge clk);
    rst = 1'b0;
    prog_we = 1'b0;
    prog_data = 8'h99;

    repeat (10) @(posedge clk);
    #1 check("we0_10clk", 32'h00010203);
    rd(32'hFC, "we0_addrFC", 32'hFCFDFEFF);
`else
    addr = 32'h2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check("rom_clk", 32'h02030405);
    end
    rst = 1'b1;
    #1 check("rom_rst_hi", 32'h02030405);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rom_rst_lo", 32'h02030405);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
